priority_arbiter: RTL

Registered N-way arbiter built on a priority-encode core. It supports fixed-priority or round-robin selection and can optionally lock a grant until release or acknowledge. It selects one requester per cycle among MAC/DMA/FIFO sources and outputs both one-hot and binary grant. It is the clocked successor of the combinational priority encoder, and it is used wherever multiple streams share one Ethernet datapath.

---
 rtl/priority_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/priority_arbiter.sv
// priority_arbiter
//   Registered N-way arbiter. Selects one requester per cycle using either
//   fixed priority or round-robin rotation. It can optionally hold a grant
//   until the granted request drops or until the granted port acknowledges.
//   All outputs are driven directly from flops.
//
// Parameters
//   PORTS                number of requesters (>= 1)
//   ARB_TYPE_ROUND_ROBIN 1 = round-robin, 0 = fixed priority
//   ARB_BLOCK            1 = hold the grant once issued
//   ARB_BLOCK_ACK        with ARB_BLOCK=1: 1 = release on acknowledge,
//                        0 = release when the granted request drops
//   LSB_HIGH_PRIORITY    1 = lowest index wins ties, 0 = highest index wins
//   LN                   grant index width (derived)
//
// Ports
//   clk            clock, all state on the rising edge
//   rst_n          synchronous reset, active-low
//   request        per-port request
//   acknowledge    per-port release (used only in acknowledge-hold mode)
//   grant          one-hot grant, registered
//   grant_valid    high when grant is non-zero
//   grant_encoded  binary index of the granted port
module priority_arbiter #(
  parameter int PORTS                = 4,
  parameter int ARB_TYPE_ROUND_ROBIN = 1,
  parameter int ARB_BLOCK            = 0,
  parameter int ARB_BLOCK_ACK        = 1,
  parameter int LSB_HIGH_PRIORITY    = 1,
  parameter int LN                   = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PORTS-1:0] request,
  input  logic [PORTS-1:0] acknowledge,
  output logic [PORTS-1:0] grant,
  output logic             grant_valid,
  output logic [LN-1:0]    grant_encoded
);

  localparam logic RR_EN    = (ARB_TYPE_ROUND_ROBIN != 0);
  localparam logic BLOCK_EN = (ARB_BLOCK != 0);
  localparam logic ACK_MODE = (ARB_BLOCK_ACK != 0);
  localparam logic LSB_HIGH = (LSB_HIGH_PRIORITY != 0);

  logic [PORTS-1:0] grant_q, grant_d;
  logic             grant_valid_q, grant_valid_d;
  logic [LN-1:0]    grant_encoded_q, grant_encoded_d;
  logic [PORTS-1:0] mask_q, mask_d;

  logic             req_hit_s;
  logic             ack_hit_s;
  logic             hold_s;
  logic [PORTS-1:0] masked_s;
  logic [PORTS-1:0] cand_s;
  logic [LN-1:0]    win_idx_s;

  // Index of the winning set bit. The loop runs from the lowest-priority
  // end toward the highest so that the last hit is the winner.
  function automatic logic [LN-1:0] pick_index(input logic [PORTS-1:0] vec);
    logic [LN-1:0] idx;
    idx = '0;
    if (LSB_HIGH) begin
      for (int i = PORTS - 1; i >= 0; i--) begin
        if (vec[i]) idx = LN'(i);
        else        idx = idx;
      end
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (vec[i]) idx = LN'(i);
        else        idx = idx;
      end
    end
    return idx;
  endfunction

  // Rotation mask after a grant to index k: only ports after k in rotation
  // order stay eligible. The last port in rotation order yields an empty mask.
  function automatic logic [PORTS-1:0] next_mask(input logic [LN-1:0] k);
    logic [PORTS-1:0] m;
    m = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (LSB_HIGH) m[i] = (LN'(i) > k);
      else          m[i] = (LN'(i) < k);
    end
    return m;
  endfunction

  // Decide whether the current grant is held this cycle.
  always_comb begin
    // grant_q is one-hot, so these match request/acknowledge[grant_encoded]
    req_hit_s = |(request & grant_q);
    ack_hit_s = |(acknowledge & grant_q);
    if (BLOCK_EN && ACK_MODE) begin
      hold_s = grant_valid_q && !ack_hit_s;
    end else if (BLOCK_EN) begin
      hold_s = grant_valid_q && req_hit_s;
    end else begin
      hold_s = 1'b0;
    end
  end

  // Candidate set and winner; round-robin falls back to the unmasked
  // request when nothing remains after the mask (wrap-around).
  always_comb begin
    masked_s = request & mask_q;
    if (RR_EN && (masked_s != '0)) begin
      cand_s = masked_s;
    end else begin
      cand_s = request;
    end
    win_idx_s = pick_index(cand_s);
  end

  // Next-state for grant outputs and rotation mask.
  always_comb begin
    grant_d         = grant_q;
    grant_valid_d   = grant_valid_q;
    grant_encoded_d = grant_encoded_q;
    mask_d          = mask_q;
    if (hold_s) begin
      grant_d         = grant_q;
      grant_valid_d   = grant_valid_q;
      grant_encoded_d = grant_encoded_q;
      mask_d          = mask_q;
    end else if (request != '0) begin
      for (int i = 0; i < PORTS; i++) begin
        grant_d[i] = (win_idx_s == LN'(i));
      end
      grant_valid_d   = 1'b1;
      grant_encoded_d = win_idx_s;
      if (RR_EN) begin
        mask_d = next_mask(win_idx_s);
      end else begin
        mask_d = '0;
      end
    end else begin
      // Idle: outputs clear, rotation position is kept.
      grant_d         = '0;
      grant_valid_d   = 1'b0;
      grant_encoded_d = '0;
      mask_d          = mask_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_q         <= '0;
      grant_valid_q   <= 1'b0;
      grant_encoded_q <= '0;
      mask_q          <= '0;
    end else begin
      grant_q         <= grant_d;
      grant_valid_q   <= grant_valid_d;
      grant_encoded_q <= grant_encoded_d;
      mask_q          <= mask_d;
    end
  end

  assign grant         = grant_q;
  assign grant_valid   = grant_valid_q;
  assign grant_encoded = grant_encoded_q;

endmodule
